// File: rtl/alu_op_issuer.sv
`timescale 1ns/1ps
// alu_op_issuer: request-side sequencer for a combinational ALU.
// Buffers {a, b, op} requests in a small FIFO and issues one at a time to
// the ALU through registered operand/op ports. It captures the ALU result
// and zero flag one cycle later and returns them on a valid/ready response
// channel.
// Ports:
//   clk, reset                    clock, async active-high reset
//   req_valid/req_ready           request handshake; req_a/req_b/req_op payload
//   alu_a/alu_b/alu_op            registered drive to the ALU
//   alu_res/alu_zero              combinational ALU result and zero flag
//   rsp_valid/rsp_ready           response handshake
//   rsp_result/rsp_zero/rsp_err   response payload
//   busy                          FIFO non-empty or sequencer active
module alu_op_issuer #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned OP_W   = 3,
  parameter int unsigned DEPTH  = 4,
  parameter logic [OP_W-1:0] MAX_OP = 3'b100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [OP_W-1:0]   req_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_res,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic              busy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   op;
  } req_t;

  typedef enum logic [1:0] {IDLE, DRIVE, HOLD} state_e;

  state_e            state_q, state_d;
  req_t              mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic              op_err_q, op_err_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic              rsp_zero_q, rsp_zero_d;
  logic              rsp_err_q, rsp_err_d;
  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;
  logic              push, pop;
  req_t              head;

  // Next-state, FIFO bookkeeping and output register inputs.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    op_err_d     = op_err_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
    pop          = 1'b0;
    push         = req_valid && req_ready_q;
    head         = mem_q[rd_ptr_q];

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        rsp_valid_d = 1'b1;
        state_d     = HOLD;
        if (op_err_q) begin
          rsp_result_d = '0;
          rsp_zero_d   = 1'b0;
          rsp_err_d    = 1'b1;
        end else begin
          rsp_result_d = alu_res;
          rsp_zero_d   = alu_zero;
          rsp_err_d    = 1'b0;
        end
      end
      HOLD: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = DRIVE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Illegal opcodes leave the ALU drive untouched; only the flag is noted.
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (head.op > MAX_OP) begin
        op_err_d = 1'b1;
      end else begin
        op_err_d = 1'b0;
        alu_a_d  = head.a;
        alu_b_d  = head.b;
        alu_op_d = head.op;
      end
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
    req_ready_d = (count_d != CNT_W'(DEPTH));
    busy_d      = (count_d != '0) || (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      op_err_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      op_err_q     <= op_err_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
    end
  end

  // FIFO storage; the pointers and count above define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{a: req_a, b: req_b, op: req_op};
    end
  end

  assign req_ready  = req_ready_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = busy_q;

endmodule
